uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx serializer among N_REQ byte-stream requesters on the clk_tx (9600 baud) domain.

---
 rtl/uart_tx_arbiter_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 78 +++++++
 tb/tb_uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared UART byte width, arbiter state encoding and watchdog width helper
package uart_tx_arbiter_pkg;
  localparam int UART_DW = 8;
  typedef enum logic {ST_IDLE, ST_XFER} state_t;
  function automatic int gap_w(input int gap_max);
    return ($clog2(gap_max + 1) > 5) ? $clog2(gap_max + 1) : 5;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker; req[N], last one-hot -> gnt one-hot, any
module uart_tx_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt,
  output logic         any
);
  int li;
  int j;
  logic found;
  // scan starts one past the previous owner and wraps, so the previous owner is checked last
  always_comb begin
    li = 0;
    for (int i = 0; i < N; i++) li = last[i] ? i : li;
    gnt = '0;
    found = 1'b0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      j = (li + k) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one uart_tx among N_REQ requesters, with idle-gap watchdog
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GAP_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [UART_DW*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [UART_DW-1:0]         d_tx,
  output logic                       vld_tx,
  input  logic                       rdy_tx,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       abort
);
  localparam int GW = gap_w(GAP_MAX);
  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d, last_q, last_d, pick;
  logic [GW-1:0]      gap_q, gap_d;
  logic               abort_q, abort_d, any, own_valid, own_last, xfer, expire;
  uart_tx_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick),
    .any  (any)
  );
  assign busy      = state_q == ST_XFER;
  assign own_valid = |(req_valid & grant_q);
  assign own_last  = |(req_last & grant_q);
  assign vld_tx    = busy && own_valid;
  assign xfer      = vld_tx && rdy_tx;
  assign req_ready = grant_q & req_valid & {N_REQ{busy && rdy_tx}};
  assign grant     = grant_q;
  assign abort     = abort_q;
  assign expire    = busy && !own_valid && gap_q == GW'(GAP_MAX - 1);
  always_comb begin
    d_tx = '0;
    for (int i = 0; i < N_REQ; i++) d_tx = d_tx | ({UART_DW{grant_q[i]}} & req_data[UART_DW*i +: UART_DW]);
  end
  // a packet ends either on its last byte or on watchdog expiry; both return to IDLE for one cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    abort_d = 1'b0;
    gap_d   = (busy && !own_valid) ? gap_q + GW'(gap_q != '1) : '0;
    if (!busy && any) begin
      state_d = ST_XFER;
      grant_d = pick;
    end else if ((xfer && own_last) || expire) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = grant_q;
      gap_d   = '0;
      abort_d = expire;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(N_REQ-1){1'b0}}};
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (N_REQ=4, GAP_MAX=16)
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx = 1'b0;
  logic [3:0]  grant;
  logic        busy;
  logic        abort;
  int n_chk = 0;
  int n_fail = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  uart_tx_arbiter #(.N_REQ(4), .GAP_MAX(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .d_tx      (d_tx),
    .vld_tx    (vld_tx),
    .rdy_tx    (rdy_tx),
    .grant     (grant),
    .busy      (busy),
    .abort     (abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_vld", 32'(vld_tx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dtx", 32'(d_tx), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_abort", 32'(abort), 0);
    rst_n = 1'b1;
    req_valid = 4'b0011;
    req_data = 32'h0000_2211;
    tick();
    chk("t1_grant", 32'(grant), 4'b0001);
    chk("t1_vld", 32'(vld_tx), 1);
    chk("t1_dtx", 32'(d_tx), 8'h11);
    rdy_tx = 1'b1;
    #1;
    chk("t1_ready", 32'(req_ready), 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_async_grant", 32'(grant), 0);
    chk("t1_async_vld", 32'(vld_tx), 0);
    chk("t1_async_busy", 32'(busy), 0);
    chk("t1_async_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("t1_req0_first", 32'(grant), 4'b0001);
    req_last = 4'b0001;
    tick();
    chk("t1_end_grant", 32'(grant), 0);
    chk("t1_end_busy", 32'(busy), 0);
    req_valid = '0;
    req_last = '0;
    rdy_tx = 1'b0;
    tick();
    req_valid = 4'b0010;
    req_data = 32'h0000_5500;
    tick();
    chk("t2_grant_a", 32'(grant), 4'b0010);
    chk("t2_dtx_a", 32'(d_tx), 8'h55);
    chk("t2_ready_lo_a", 32'(req_ready), 0);
    rdy_tx = 1'b1;
    #1;
    chk("t2_ready_a", 32'(req_ready), 4'b0010);
    tick();
    req_data = 32'h0000_AA00;
    req_last = 4'b0010;
    rdy_tx = 1'b0;
    #1;
    chk("t2_grant_b", 32'(grant), 4'b0010);
    chk("t2_dtx_b", 32'(d_tx), 8'hAA);
    chk("t2_ready_lo_b", 32'(req_ready), 0);
    rdy_tx = 1'b1;
    #1;
    chk("t2_ready_b", 32'(req_ready), 4'b0010);
    tick();
    chk("t2_idle_busy", 32'(busy), 0);
    chk("t2_idle_grant", 32'(grant), 0);
    req_valid = '0;
    req_last = '0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    req_data = 32'hD3D2_D1D0;
    rdy_tx = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_grant", 32'(grant), 32'(1) << order[k]);
      chk("t3_dtx", 32'(d_tx), 32'(8'hD0 + order[k]));
      tick();
      chk("t3_gap_grant", 32'(grant), 0);
      chk("t3_gap_busy", 32'(busy), 0);
    end
    req_valid = '0;
    req_last = '0;
    rdy_tx = 1'b0;
    tick();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    tick();
    chk("t4_grant", 32'(grant), 4'b0100);
    for (int i = 0; i < 20; i++) begin
      chk("t4_abort", 32'(abort), 0);
      chk("t4_dtx", 32'(d_tx), 8'hD2);
      chk("t4_busy", 32'(busy), 1);
      tick();
    end
    rdy_tx = 1'b1;
    #1;
    chk("t4_ready", 32'(req_ready), 4'b0100);
    tick();
    chk("t4_idle", 32'(busy), 0);
    req_valid = 4'b1000;
    req_last = '0;
    tick();
    chk("t5_grant", 32'(grant), 4'b1000);
    tick();
    req_valid = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_noabort", 32'(abort), 0);
      chk("t5_hold_grant", 32'(grant), 4'b1000);
    end
    tick();
    chk("t5_abort", 32'(abort), 1);
    chk("t5_abort_grant", 32'(grant), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    tick();
    chk("t5_abort_once", 32'(abort), 0);
    chk("t5_next_grant", 32'(grant), 4'b0001);
    req_last = 4'b0001;
    tick();
    req_valid = 4'b0010;
    req_last = '0;
    tick();
    chk("t5b_grant", 32'(grant), 4'b0010);
    tick();
    req_valid = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5b_noabort", 32'(abort), 0);
    end
    req_valid = 4'b0010;
    req_last = 4'b0010;
    #1;
    chk("t5b_resume_grant", 32'(grant), 4'b0010);
    chk("t5b_resume_ready", 32'(req_ready), 4'b0010);
    tick();
    chk("t5b_end_abort", 32'(abort), 0);
    chk("t5b_end_busy", 32'(busy), 0);
    req_valid = 4'b0100;
    req_last = '0;
    rdy_tx = 1'b0;
    tick();
    chk("t6_grant", 32'(grant), 4'b0100);
    for (int i = 0; i < 6; i++) begin
      req_valid[3] = i[0];
      req_last[3] = i[1];
      req_data[31:24] = 8'(i * 37);
      rdy_tx = (i % 3) == 0;
      #1;
      chk("t6_ready", 32'(req_ready), rdy_tx ? 4'b0100 : 4'b0000);
      chk("t6_dtx", 32'(d_tx), 8'hD2);
      chk("t6_grant_hold", 32'(grant), 4'b0100);
      tick();
    end
    req_valid = 4'b1100;
    req_last = 4'b0100;
    rdy_tx = 1'b1;
    tick();
    chk("t6_end_grant", 32'(grant), 0);
    req_valid = '0;
    req_last = '0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
